invmux_ccff_n: RTL

Parametrised N-input inverting routing multiplexer with an integrated configuration-chain (CCFF) segment and atomic select commit. Replaces the fixed 2- and 3-input inverting mux cells in the routing fabric: the one-hot select pattern is shifted in serially on the programming chain, staged in a shadow register, and applied to the datapath in a single commit. The block sits in a switch/connection box and daisy-chains to its neighbours through `ccff_head`/`ccff_tail`.

---
 rtl/invmux_ccff_n.sv | 129 ++++++++++++
 1 files changed

// File: rtl/invmux_ccff_n.sv
// invmux_ccff_n: N-input inverting routing mux with an integrated configuration-chain
// segment and atomic select commit.
//
// The one-hot select is shifted in serially on ccff_head and staged in a shadow register
// (sr). Once N_INPUTS bits have been loaded, ccff_commit copies sr into the active select
// (sel) in one edge. The serial chain continues through ccff_tail to the next block.
//
// Ports:
//   prog_clk     programming clock; all state changes on its rising edge
//   pReset       synchronous active-high reset
//   ccff_head    serial configuration data in
//   ccff_en      shift enable, one bit per cycle
//   ccff_commit  copy shadow register to active select (honoured only when full)
//   ccff_tail    serial configuration data out (sr[N_INPUTS-1])
//   Q            data inputs
//   Z            inverted selected input (combinational)
//   cfg_busy     high whenever the FSM is not idle
//   cfg_done     one-cycle pulse in the cycle the active select changes
//   onehot_err   active select not exactly one-hot
//
// Configuration macro: INVMUX_ONEHOT_CHECK_EN
//   defined   -> onehot_err flags a non-one-hot select and forces Z to 0
//   undefined -> onehot_err tied to 0; Z is the wired-OR of the selected inverted inputs
module invmux_ccff_n #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  input  logic [N_INPUTS-1:0] Q,
  output logic                Z,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                onehot_err
);

  typedef enum logic [1:0] {StIdle, StShift, StFull} state_e;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(N_INPUTS);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N_INPUTS - 1);

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] sr_q, sr_d;
  logic [N_INPUTS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      sel_q   <= N_INPUTS'(1);
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    // The chain shifts on every enabled cycle in any state so neighbours keep streaming.
    if (ccff_en) begin
      sr_d = {sr_q[N_INPUTS-2:0], ccff_head};
    end

    unique case (state_q)
      StIdle: begin
        if (ccff_en) begin
          cnt_d   = CNT_W'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        // Commit is ignored here: the shadow data is still incomplete.
        if (ccff_en) begin
          if (cnt_q >= CntLast) begin
            cnt_d   = CntFull;
            state_d = StFull;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StFull: begin
        if (ccff_commit) begin
          // sr_q is the pre-shift value even if ccff_en is high this cycle.
          sel_d   = sr_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ccff_tail = sr_q[N_INPUTS-1];
  assign cfg_busy  = (state_q != StIdle);
  assign cfg_done  = done_q;

  logic z_or;
  assign z_or = |(~Q & sel_q);

`ifdef INVMUX_ONEHOT_CHECK_EN
  logic sel_onehot;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - N_INPUTS'(1))) == '0);
  assign onehot_err = ~sel_onehot;
  assign Z          = sel_onehot & z_or;
`else
  assign onehot_err = 1'b0;
  assign Z          = z_or;
`endif

endmodule
